vga_sync_gen: RTL

Timing generator for the 640x480@60 Hz VGA path. It divides the board clock down to a pixel-rate enable and runs the horizontal and vertical counters. It produces `hsync`, `vsync`, `vidon`, `hc` and `vc`, which drive the monitor and every downstream pixel-pattern block. This is the source end of the `vidon`/`hc`/`vc` interface those blocks consume.

---
 rtl/vga_sync_gen_pkg.sv | 25 ++
 rtl/vga_sync_gen_if.sv | 27 ++
 rtl/vga_sync_gen_pix.sv | 31 +++
 rtl/vga_sync_gen.sv | 91 +++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// vga_pkg: 640x480@60 Hz timing constants shared by the sync generator,
// its interface and downstream pixel blocks.
//   H_* / V_*     : sync, back porch, active and front porch widths
//   H_TOT / V_TOT : total pixels per line / lines per frame
//   *_END/*_START : active-window edges, in counter units
//   CW            : counter width for hc / vc
package vga_pkg;
    localparam int CW        = 10;

    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_ACT     = 640;
    localparam int H_FP      = 16;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_ACT     = 480;
    localparam int V_FP      = 10;

    localparam int H_TOT     = H_SYNC + H_BP + H_ACT + H_FP;   // 800
    localparam int V_TOT     = V_SYNC + V_BP + V_ACT + V_FP;   // 525
    localparam int HBP_END   = H_SYNC + H_BP;                  // 144
    localparam int HFP_START = HBP_END + H_ACT;                // 784
    localparam int VBP_END   = V_SYNC + V_BP;                  // 35
    localparam int VFP_START = VBP_END + V_ACT;                // 515
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: timing bundle from the sync generator to its consumers.
//   pix_en      : one-clk pixel strobe
//   hc, vc      : raw horizontal / vertical counts
//   hsync/vsync : active-low syncs
//   vidon       : inside active window
//   line_start  : one-clk pulse while hc first shows 0
//   frame_start : one-clk pulse while hc and vc first show 0
// master = generator side, slave = consumer side.
interface vga_sync_gen_if;
    import vga_pkg::*;

    logic          pix_en;
    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          hsync;
    logic          vsync;
    logic          vidon;
    logic          line_start;
    logic          frame_start;

    modport master (
        output pix_en, hc, vc, hsync, vsync, vidon, line_start, frame_start
    );
    modport slave (
        input  pix_en, hc, vc, hsync, vsync, vidon, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen_pix.sv
// pix_clk_en: divides the board clock to a registered pixel strobe.
//   clk    : board clock
//   clr    : synchronous active-high reset
//   pix_en : high for one clk out of every CLK_DIV (always high when CLK_DIV=1)
module pix_clk_en #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic clr,
    output logic pix_en
);
    // Keep at least one bit so CLK_DIV=1 still elaborates a legal vector.
    localparam int            DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_div_chk
        $error("pix_clk_en: CLK_DIV must be >= 1");
    end

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            div_cnt <= '0;
            pix_en  <= 1'b0;
        end else begin
            pix_en  <= (div_cnt == LAST);
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + DW'(1);
        end
    end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator (default 640x480@60 Hz).
//   clk, clr : board clock, synchronous active-high reset
//   vga      : timing bundle (master side) -- pix_en, hc, vc, hsync, vsync,
//              vidon, line_start, frame_start
// Counters advance only on pix_en; syncs and vidon decode the registered
// counters combinationally so they stay aligned with hc/vc.
module vga_sync_gen #(
    parameter int CLK_DIV = 2,
    parameter int H_SYNC  = vga_pkg::H_SYNC,
    parameter int H_BP    = vga_pkg::H_BP,
    parameter int H_ACT   = vga_pkg::H_ACT,
    parameter int H_FP    = vga_pkg::H_FP,
    parameter int V_SYNC  = vga_pkg::V_SYNC,
    parameter int V_BP    = vga_pkg::V_BP,
    parameter int V_ACT   = vga_pkg::V_ACT,
    parameter int V_FP    = vga_pkg::V_FP
) (
    input  logic           clk,
    input  logic           clr,
    vga_sync_gen_if.master vga
);
    import vga_pkg::CW;

    localparam int HT     = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int VT     = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int HA_BEG = H_SYNC + H_BP;
    localparam int HA_END = HA_BEG + H_ACT;
    localparam int VA_BEG = V_SYNC + V_BP;
    localparam int VA_END = VA_BEG + V_ACT;

    if (HT > 2**CW || VT > 2**CW) begin : g_tot_chk
        $error("vga_sync_gen: H_TOT/V_TOT exceed counter range");
    end

    localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
    localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
    localparam logic [CW-1:0] HS_END = CW'(H_SYNC);
    localparam logic [CW-1:0] VS_END = CW'(V_SYNC);
    localparam logic [CW-1:0] HA_LO  = CW'(HA_BEG);
    localparam logic [CW-1:0] HA_HI  = CW'(HA_END);
    localparam logic [CW-1:0] VA_LO  = CW'(VA_BEG);
    localparam logic [CW-1:0] VA_HI  = CW'(VA_END);

    logic          pix_en;
    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          line_start;
    logic          frame_start;
    logic          h_wrap;
    logic          v_wrap;

    pix_clk_en #(.CLK_DIV(CLK_DIV)) u_pix (
        .clk    (clk),
        .clr    (clr),
        .pix_en (pix_en)
    );

    // Line wrap happens only on a pixel strobe; frame wrap is a line wrap
    // on the last line.
    assign h_wrap = pix_en && (hc == H_LAST);
    assign v_wrap = h_wrap && (vc == V_LAST);

    always_ff @(posedge clk) begin
        if (clr) begin
            hc          <= '0;
            vc          <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // Pulses register the wrap so they appear with hc=0.
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            if (pix_en) begin
                hc <= h_wrap ? '0 : hc + CW'(1);
            end
            if (h_wrap) begin
                vc <= v_wrap ? '0 : vc + CW'(1);
            end
        end
    end

    assign vga.pix_en      = pix_en;
    assign vga.hc          = hc;
    assign vga.vc          = vc;
    assign vga.line_start  = line_start;
    assign vga.frame_start = frame_start;
    assign vga.hsync       = (hc >= HS_END);
    assign vga.vsync       = (vc >= VS_END);
    assign vga.vidon       = (hc >= HA_LO) && (hc < HA_HI) &&
                             (vc >= VA_LO) && (vc < VA_HI);
endmodule
